// File: rtl/sync_sweep_driver.sv
// rtl/sync_sweep_driver.sv - sweep initiator for the sync valid/ready call protocol
// Issues first..last to one callee, one call at a time, tracking sum and worst latency.
module sync_sweep_driver #(
  parameter int N       = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  input  logic [N-1:0] first,
  input  logic [N-1:0] last,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         req_valid,
  input  logic         req_ready,
  output logic [N-1:0] req_arg,
  input  logic         rsp_valid,
  output logic         rsp_ready,
  input  logic [N-1:0] rsp_data,
  output logic         res_valid,
  output logic [N-1:0] res_arg,
  output logic [N-1:0] res_data,
  output logic [N-1:0] sum,
  output logic [N-1:0] max_lat
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // TIMEOUT is an int, so a 32-bit counter always reaches it
  localparam int CW = (N > 32) ? N : 32;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_last;
  logic [N-1:0]  r_req_arg;
  logic [N-1:0]  r_res_arg;
  logic [N-1:0]  r_res_data;
  logic [N-1:0]  r_sum;
  logic [N-1:0]  r_max_lat;
  logic          r_res_valid;
  logic          r_err;

  logic          w_timeout;
  logic          w_last_call;
  logic [N-1:0]  w_lat;

  assign w_timeout   = (r_cnt >= TO_LIMIT);
  assign w_last_call = (r_req_arg == r_last);
  assign w_lat       = (|(r_cnt >> N)) ? {N{1'b1}} : r_cnt[N-1:0];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ISSUE;
      S_ISSUE: if (req_ready) w_next = S_WAIT;
      S_WAIT: begin
        // a response arriving on the timeout cycle still counts as a result
        if (rsp_valid) begin
          w_next = w_last_call ? S_DONE : S_ISSUE;
        end else if (w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    case (r_state)
      S_ISSUE: begin
        busy      = 1'b1;
        req_valid = 1'b1;
      end
      S_WAIT: begin
        busy      = 1'b1;
        rsp_ready = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_cnt       <= '0;
      r_last      <= '0;
      r_req_arg   <= '0;
      r_res_arg   <= '0;
      r_res_data  <= '0;
      r_sum       <= '0;
      r_max_lat   <= '0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_last    <= last;
            r_req_arg <= first;
            r_sum     <= '0;
            r_max_lat <= '0;
            r_err     <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (req_ready) r_cnt <= CW'(1);
        end
        S_WAIT: begin
          if (rsp_valid) begin
            r_res_valid <= 1'b1;
            r_res_arg   <= r_req_arg;
            r_res_data  <= rsp_data;
            r_sum       <= r_sum + rsp_data;
            r_max_lat   <= (w_lat > r_max_lat) ? w_lat : r_max_lat;
            if (!w_last_call) r_req_arg <= r_req_arg + N'(1);
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign err       = r_err;
  assign req_arg   = r_req_arg;
  assign res_valid = r_res_valid;
  assign res_arg   = r_res_arg;
  assign res_data  = r_res_data;
  assign sum       = r_sum;
  assign max_lat   = r_max_lat;

endmodule

// File: doc/sync_sweep_driver.md
# sync_sweep_driver

Synthesizable initiator for the `sync` valid/ready call protocol used by the generated function modules. It issues a sweep of arguments `first..last` to a single callee, one outstanding call at a time. Each returned result is forwarded on a result port, and the block accumulates a running sum and worst-case call latency. It sits between on-chip control logic and a generated callee, replacing the behavioural stimulus loop of a bench with a reusable hardware harness.

## Interface
Parameters:
- `N`, 16, width of argument and result words (matches `intN`).
- `TIMEOUT`, 1024, maximum cycles allowed between request handshake and response handshake; must be at least 1.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `nrst`  in  1  reset, synchronous, active-low.
- `start`  in  1  begins a sweep; sampled only in IDLE.
- `first`  in  N  first argument; captured on accepted `start`.
- `last`  in  N  final argument; captured on accepted `start`.
- `busy`  out  1  high in ISSUE, WAIT and DONE.
- `done`  out  1  one-cycle pulse at end of sweep.
- `err`  out  1  set on timeout; valid with `done`; cleared on next accepted `start`.
- `req_valid`  out  1  drives callee `in_valid`.
- `req_ready`  in  1  from callee `in_ready`.
- `req_arg`  out  N  drives callee `in0`.
- `rsp_valid`  in  1  from callee `out_valid`.
- `rsp_ready`  out  1  drives callee `out_ready`.
- `rsp_data`  in  N  from callee `out0`.
- `res_valid`  out  1  one-cycle pulse per captured result.
- `res_arg`  out  N  argument of the captured result.
- `res_data`  out  N  captured result.
- `sum`  out  N  running sum of results, mod 2^N.
- `max_lat`  out  N  worst observed latency in cycles, saturating at 2^N-1.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- Reset (`nrst`=0 at an edge): state IDLE. All outputs 0, including `sum`, `max_lat`, `err`, `req_arg`, `res_*`. The latency counter is 0. Reset applies in any state and abandons an in-flight call, with no further handshake.
- IDLE:
  - `start`=1 captures `first` and `last`.
  - Sets `req_arg`=`first`; clears `sum`, `max_lat`, `err`.
  - Next state ISSUE.
- ISSUE:
  - `req_valid`=1 with `req_arg` held stable until the handshake.
  - On `req_valid & req_ready`: latency counter set to 1; next state WAIT.
- WAIT:
  - `rsp_ready`=1; the latency counter increments each cycle.
  - On `rsp_valid`:
    - Register `res_arg`=`req_arg` and `res_data`=`rsp_data`, and pulse `res_valid`.
    - `sum` += `rsp_data`, mod 2^N.
    - `max_lat` = max(`max_lat`, counter).
    - If `req_arg`==`last`, go to DONE. Otherwise `req_arg`+1 (wraps mod 2^N) and go to ISSUE.
  - If the counter reaches `TIMEOUT` without `rsp_valid`: set `err`=1 and go to DONE. No `res_valid` is produced.
- DONE:
  - `done`=1 for exactly one cycle; next state IDLE.
- The sweep count is (`last`-`first`) mod 2^N + 1. `first`>`last` wraps through 2^N-1 to 0; `first`==`last` issues exactly one call.
- `req_valid` and `rsp_ready` are never high in the same cycle, so at most one call is outstanding.
- `start` outside IDLE is ignored.

## Timing
- `start` accepted at edge t: `req_valid`=1 from t+1.
- Request handshake at edge h, response at edge r: latency = r-h. `res_valid`, `sum` and `max_lat` update visible after r. Next `req_valid` from r+1.
- Minimum per-call period is 2 cycles (ISSUE 1, WAIT 1) when the callee responds on the cycle after acceptance.
- `done` is high the cycle after the final response or the timeout. `busy` falls the cycle after `done`.
- A `rsp_valid` arriving while in ISSUE or IDLE is ignored (`rsp_ready`=0).
- If `rsp_valid` arrives in the same cycle that the counter reaches `TIMEOUT`, the response wins and no error is raised.

## Test plan
- Callee is an identity function with 1-cycle response. Sweep 3..6 → `res_data` 3,4,5,6 on four `res_valid` pulses; `sum`=18; `max_lat`=1; one `done` pulse; `err`=0.
- Callee is a Fibonacci model with variable latency. Sweep 21..21 → single result 10946; `max_lat` equals the injected delay (e.g. 7).
- Wrap-around with an identity callee at N=16. Sweep 65534..1 → arguments 65534, 65535, 0, 1 in that order; `sum`=(65534+65535+0+1) mod 65536=65534.
- Backpressure: hold `req_ready`=0 for 5 cycles → `req_valid` stays high with `req_arg` stable; the latency counter does not start until the handshake.
- Timeout with `TIMEOUT`=8 and a callee that never responds → `err`=1 with `done` 8 cycles after the request handshake; no `res_valid`. A following `start` clears `err`.
- Reset mid-sweep: `nrst`=0 in WAIT → next cycle IDLE, all outputs 0. A late `rsp_valid` is ignored; a fresh `start` runs normally.
